// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: walks the image memory, re-aligns sync/blanking
// to the memory read latency and registers the VGA output.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int RD_LAT  = 1,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  im_pixel_x,
  output logic [9:0]  im_pixel_y,
  input  logic [11:0] im_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VL   = 10'(H_VIS);
  localparam logic [9:0] V_VL   = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
  } sync_t;

  localparam sync_t SYNC_RST = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          fs_q, fs_d;
  logic          pix_tick;
  sync_t         raw;
  sync_t         pipe_q [RD_LAT:0];
  sync_t         pipe_d [RD_LAT:0];
  sync_t         aligned;
  logic [11:0]   rgb_q;
  logic          hs_q, vs_q, von_q;

  assign pix_tick = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    fs_d  = 1'b0;
    if (pix_tick) begin
      div_d = '0;
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Stage 0 of the sync pipe is registered alongside the address it describes.
  always_comb begin
    raw.vis  = (h_q < H_VL) && (v_q < V_VL);
    raw.hs_n = !((h_q >= HS_BEG) && (h_q < HS_END));
    raw.vs_n = !((v_q >= VS_BEG) && (v_q < VS_END));
    x_d      = raw.vis ? h_q : 10'd0;
    y_d      = raw.vis ? v_q : 10'd0;
    pipe_d[0] = raw;
    for (int i = 1; i <= RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign aligned = pipe_q[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= SYNC_RST;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= pipe_d[i];
      rgb_q <= aligned.vis ? im_rgb : 12'h000;
      hs_q  <= aligned.hs_n;
      vs_q  <= aligned.vs_n;
      von_q <= aligned.vis;
    end
  end

  assign im_pixel_x  = x_q;
  assign im_pixel_y  = y_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign video_on    = von_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-geometry instances plus one full 640-wide
// instance, checked against a closed-form raster model every clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Clocks since the last reset edge (0 right after the edge that sampled rst).
  int n = 0;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  typedef struct {
    int   t;
    obs_t e;
  } vec_t;

  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVV = 6,  SVF = 2, SVS = 2, SVB = 2;

  logic [9:0]  xA, yA, xB, yB, xC, yC;
  logic [11:0] rgbA, rgbB, rgbC;
  logic [3:0]  rA, gA, bA, rB, gB, bB, rC, gC, bC;
  logic        hsA, vsA, vonA, fsA, hsB, vsB, vonB, fsB, hsC, vsC, vonC, fsC;
  logic [11:0] mB [3];
  obs_t        oA, oB, oC;

  vga_timing_gen #(.CLK_DIV(4), .RD_LAT(1), .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) dA (
    .clk(clk), .rst(rst), .im_pixel_x(xA), .im_pixel_y(yA), .im_rgb(rgbA),
    .vga_r(rA), .vga_g(gA), .vga_b(bA), .vga_hsync(hsA), .vga_vsync(vsA),
    .video_on(vonA), .frame_start(fsA));

  vga_timing_gen #(.CLK_DIV(1), .RD_LAT(3), .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) dB (
    .clk(clk), .rst(rst), .im_pixel_x(xB), .im_pixel_y(yB), .im_rgb(rgbB),
    .vga_r(rB), .vga_g(gB), .vga_b(bB), .vga_hsync(hsB), .vga_vsync(vsB),
    .video_on(vonB), .frame_start(fsB));

  vga_timing_gen #(.CLK_DIV(1), .RD_LAT(1)) dC (
    .clk(clk), .rst(rst), .im_pixel_x(xC), .im_pixel_y(yC), .im_rgb(rgbC),
    .vga_r(rC), .vga_g(gC), .vga_b(bC), .vga_hsync(hsC), .vga_vsync(vsC),
    .video_on(vonC), .frame_start(fsC));

  // Image memories: colour encodes the coordinates, latency matches each RD_LAT.
  always @(posedge clk) rgbA <= {xA[3:0], yA[3:0], 4'hA};
  always @(posedge clk) rgbC <= {xC[3:0], yC[3:0], 4'hA};
  always @(posedge clk) begin
    mB[0] <= {xB[3:0], yB[3:0], 4'hA};
    mB[1] <= mB[0];
    mB[2] <= mB[1];
  end
  assign rgbB = mB[2];

  assign oA = {xA, yA, vonA, hsA, vsA, rA, gA, bA, fsA};
  assign oB = {xB, yB, vonB, hsB, vsB, rB, gB, bB, fsB};
  assign oC = {xC, yC, vonC, hsC, vsC, rC, gC, bC, fsC};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  // Outputs after clock t: address from counters one clock earlier, VGA side from
  // counters RD_LAT+2 clocks earlier; pixel index advances every cd clocks.
  function automatic obs_t model(input int cd, input int rl, input int hv, input int hf,
                                 input int hsy, input int hb, input int vv, input int vf,
                                 input int vsy, input int vb, input int t);
    int ht, vt, p, h, v;
    obs_t o;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (t >= 1) begin
      p = (t - 1) / cd; h = p % ht; v = (p / ht) % vt;
      if (h < hv && v < vv) begin o.x = 10'(h); o.y = 10'(v); end
    end
    if (t >= rl + 2) begin
      p = (t - rl - 2) / cd; h = p % ht; v = (p / ht) % vt;
      o.von = (h < hv) && (v < vv);
      o.hs  = !(h >= hv + hf && h < hv + hf + hsy);
      o.vs  = !(v >= vv + vf && v < vv + vf + vsy);
      if (o.von) o.rgb = {4'(h), 4'(v), 4'hA};
    end
    o.fs = (t > 0) && (t % (cd * ht * vt) == 0);
    return o;
  endfunction

  logic chk_en = 1'b0;
  logic hsC_p = 1'b1, vsA_p = 1'b1, vonB_p = 1'b0;
  int fsA_q[$], fsB_q[$], hcF[$], hcR[$], vaF[$], vaR[$], vbR[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("strmA", oA, model(4, 1, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, n));
      chk("strmB", oB, model(1, 3, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, n));
      chk("strmC", oC, model(1, 1, 640, 16, 96, 48, 480, 10, 2, 33, n));
      if (fsA) fsA_q.push_back(n);
      if (fsB) fsB_q.push_back(n);
      if (!hsC && hsC_p) hcF.push_back(n);
      if (hsC && !hsC_p) hcR.push_back(n);
      if (!vsA && vsA_p) vaF.push_back(n);
      if (vsA && !vsA_p) vaR.push_back(n);
      if (vonB && !vonB_p) vbR.push_back(n);
    end
    hsC_p  = hsC;
    vsA_p  = vsA;
    vonB_p = vonB;
  end

  function automatic vec_t mk(input int t, input int x, input int y, input logic von,
                              input logic hs, input logic vs, input logic [11:0] rgb,
                              input logic fs);
    vec_t r;
    r.t = t;
    r.e = {10'(x), 10'(y), von, hs, vs, rgb, fs};
    return r;
  endfunction

  task automatic wait_n(input int target, input string nm);
    int guard = 0;
    while (n < target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_sync"}, 64'(n), 64'(target));
  endtask

  vec_t tv[22];

  initial begin
    // Hand-computed samples of instance A (CLK_DIV=4, RD_LAT=1, 25x12 raster).
    tv[0]  = mk(0,    0, 0, 0, 1, 1, 12'h000, 0);
    tv[1]  = mk(2,    0, 0, 0, 1, 1, 12'h000, 0);
    tv[2]  = mk(3,    0, 0, 1, 1, 1, 12'h00A, 0);
    tv[3]  = mk(5,    1, 0, 1, 1, 1, 12'h00A, 0);
    tv[4]  = mk(7,    1, 0, 1, 1, 1, 12'h10A, 0);
    tv[5]  = mk(64,  15, 0, 1, 1, 1, 12'hF0A, 0);
    tv[6]  = mk(68,   0, 0, 0, 1, 1, 12'h000, 0);
    tv[7]  = mk(74,   0, 0, 0, 1, 1, 12'h000, 0);
    tv[8]  = mk(75,   0, 0, 0, 0, 1, 12'h000, 0);
    tv[9]  = mk(90,   0, 0, 0, 0, 1, 12'h000, 0);
    tv[10] = mk(91,   0, 0, 0, 1, 1, 12'h000, 0);
    tv[11] = mk(103,  0, 1, 1, 1, 1, 12'h01A, 0);
    tv[12] = mk(563, 15, 5, 1, 1, 1, 12'hF5A, 0);
    tv[13] = mk(567,  0, 0, 0, 1, 1, 12'h000, 0);
    tv[14] = mk(802,  0, 0, 0, 1, 1, 12'h000, 0);
    tv[15] = mk(803,  0, 0, 0, 1, 0, 12'h000, 0);
    tv[16] = mk(1002, 0, 0, 0, 1, 0, 12'h000, 0);
    tv[17] = mk(1003, 0, 0, 0, 1, 1, 12'h000, 0);
    tv[18] = mk(1199, 0, 0, 0, 1, 1, 12'h000, 0);
    tv[19] = mk(1200, 0, 0, 0, 1, 1, 12'h000, 1);
    tv[20] = mk(1201, 0, 0, 0, 1, 1, 12'h000, 0);
    tv[21] = mk(1203, 0, 0, 1, 1, 1, 12'h00A, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      wait_n(tv[i].t, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d", i), oA, tv[i].e);
    end

    // Instance C line 3, h=700: measure periods, then reset mid-line.
    wait_n(3100, "pre_rst");
    chk("fsA_cnt", 64'(fsA_q.size()), 64'd2);
    if (fsA_q.size() >= 2) begin
      chk("fsA_first", 64'(fsA_q[0]), 64'd1200);
      chk("fsA_period", 64'(fsA_q[1] - fsA_q[0]), 64'd1200);
    end
    chk("fsB_cnt", 64'(fsB_q.size()), 64'd10);
    if (fsB_q.size() >= 2) chk("fsB_period", 64'(fsB_q[1] - fsB_q[0]), 64'd300);
    chk("hsC_cnt", 64'(hcF.size()), 64'd4);
    if (hcF.size() >= 2 && hcR.size() >= 1) begin
      chk("hsC_fall", 64'(hcF[0]), 64'd659);
      chk("hsC_width", 64'(hcR[0] - hcF[0]), 64'd96);
      chk("hsC_period", 64'(hcF[1] - hcF[0]), 64'd800);
    end
    chk("vsA_cnt", 64'(vaF.size()), 64'd2);
    if (vaF.size() >= 1 && vaR.size() >= 1) begin
      chk("vsA_fall", 64'(vaF[0]), 64'd803);
      chk("vsA_width", 64'(vaR[0] - vaF[0]), 64'd200);
    end

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fsA_q.delete(); vbR.delete();
    chk("rstA", oA, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0});
    chk("rstC", oC, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0});

    @(negedge clk);
    wait_n(1300, "post_rst");
    chk("vonB_rise_cnt", 64'(vbR.size() > 0), 64'd1);
    if (vbR.size() > 0) chk("vonB_rise", 64'(vbR[0]), 64'd5);
    chk("fsA_post_cnt", 64'(fsA_q.size()), 64'd1);
    if (fsA_q.size() > 0) chk("fsA_post", 64'(fsA_q[0]), 64'd1200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster scan generator that reads the image memory (`iob_im`) and drives a 640x480@60 Hz VGA port. It produces the pixel coordinates the image memory consumes, takes back the 12-bit RGB it returns, and re-aligns sync/blanking to the memory read latency. It sits between `iob_im` and the board VGA connector, clocked by the 100 MHz system clock with a pixel-enable divider.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal values ≥1.
- `RD_LAT`, 1, clocks from `im_pixel_x/y` change to valid `im_rgb`; legal values 0..8.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `im_pixel_x`  out  10  column address to image memory.
- `im_pixel_y`  out  10  row address to image memory.
- `im_rgb`  in  12  pixel colour from image memory, {R[3:0],G[3:0],B[3:0]}.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour to DAC.
- `vga_hsync`  out  1  horizontal sync, active-low.
- `vga_vsync`  out  1  vertical sync, active-low.
- `video_on`  out  1  high while visible pixel is on the output (aligned with `vga_r/g/b`).
- `frame_start`  out  1  one-clock pulse at start of each frame.

## Operation
- `div_cnt` counts 0..CLK_DIV-1, wraps; `pix_tick` = (div_cnt == CLK_DIV-1).
- `h_cnt` 0..799, advances on `pix_tick`; at 799 wraps to 0 and `v_cnt` advances; `v_cnt` 0..524, wraps to 0.
- Horizontal: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- `im_pixel_x/y` registered: = h_cnt/v_cnt when both visible, else 0 (memory never sees out-of-range addresses).
- Raw `vis`, `hs_n` (low when h_cnt in 656..751), `vs_n` (low when v_cnt in 490..491) pass through an RD_LAT-deep clock delay line, aligned to `im_rgb`.
- Output stage registered: `vga_r/g/b` = delayed vis ? `im_rgb` fields : 0; `vga_hsync`, `vga_vsync`, `video_on` = delayed values.
- `frame_start` high for exactly one clock, on the clock where counters go (799,524) -> (0,0); not asserted by reset itself.
- Counter widths: `h_cnt`, `v_cnt` 10-bit, compares exact; `div_cnt` `$clog2(CLK_DIV)` bits, minimum 1.

## Timing
- Reset values: all counters 0; `im_pixel_x/y` = 0; `vga_r/g/b` = 0; `vga_hsync` = `vga_vsync` = 1; `video_on` = 0; `frame_start` = 0; delay line cleared to vis=0, hs_n=vs_n=1.
- `rst` sampled high mid-frame: next clock is state (0,0,div 0); outputs take reset values that clock; the delay line flushes so no stale colour or sync escapes.
- Address-to-output latency: `vga_*` lags `im_pixel_x/y` by RD_LAT+1 clocks; sync and blanking lag by the same amount, so colour/sync alignment is exact for any legal RD_LAT.
- First pixel (0,0) after reset release: `im_pixel_x/y`=(0,0) from first clock after release; `video_on` first high RD_LAT+2 clocks after release.
- Line = 800·CLK_DIV clocks (3200); frame = 525 lines (1 680 000 clocks).
- hsync low 96·CLK_DIV clocks (384) per line; vsync low 2 lines (6400 clocks) per frame.
- `video_on` high 640·CLK_DIV clocks per visible line, 0 on lines 480-524.
- Simultaneous h and v wrap on same `pix_tick`: both wrap in one clock, `frame_start` fires that clock.

## Test plan
- Reset then run 2 frames, defaults -> `frame_start` period exactly 1 680 000 clocks; 525 hsync pulses per frame, each 384 clocks low, 3200 clocks apart.
- vsync check -> low exactly 6400 clocks, falling edge coinciding (same clock) with hsync-high region start of line 490 at output latency.
- Memory model returning rgb = {x[3:0], y[3:0], 4'hA} with RD_LAT=1, then RD_LAT=3 -> each visible output pixel matches its coordinates; border pixels (0,0),(639,479) correct; blanking colour 0.
- Address bounds -> `im_pixel_x` never >639, `im_pixel_y` never >479; both 0 throughout blanking.
- Assert `rst` for 1 clock at h=700, v=300 -> next clock all outputs at reset values; `video_on` rises RD_LAT+2 clocks after release; no `frame_start` until 1 680 000 clocks later.
- CLK_DIV=1 -> line 800 clocks, hsync low 96 clocks, frame 420 000 clocks.
